// File: rtl/nios1_div_pkg.sv
// Shared definitions for the Nios II iterative divide cell: FSM encoding,
// counter sizing and the divide-by-zero quotient pattern.
package nios1_div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/nios1_nios2_qsys_div_cell_step.sv
// One combinational radix-2 restoring step: trial subtract, quotient bit
// and next partial remainder.
module nios1_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic             q_bit,
    output logic [WIDTH-1:0] rem_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // A set shifted[WIDTH] already exceeds any divisor; otherwise the
    // WIDTH+1-bit difference's top bit is its sign.
    always_comb begin
        shifted  = {rem, dividend_msb};
        trial    = shifted - {1'b0, divisor};
        q_bit    = shifted[WIDTH] | ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/nios1_nios2_qsys_div_cell.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per
// cycle, sign fix-up in a dedicated cycle, one-cycle done pulse.
module nios1_nios2_qsys_div_cell
    import nios1_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    input  logic             A_div_signed,
    input  logic             A_div_start,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder
);

    localparam int unsigned CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DZ_QUOT = (WIDTH == DIV_WIDTH) ? WIDTH'(DIV_DZ_QUOT) : '1;

    div_state_t state_q;
    div_state_t state_d;

    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] src1_mag;
    logic [WIDTH-1:0] src2_mag;
    logic             step_q_bit;
    logic [WIDTH-1:0] step_rem;

    always_comb begin
        src1_mag = (A_div_signed && A_div_src1[WIDTH-1]) ? -A_div_src1 : A_div_src1;
        src2_mag = (A_div_signed && A_div_src2[WIDTH-1]) ? -A_div_src2 : A_div_src2;
    end

    nios1_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem         (rem_q),
        .dividend_msb(dividend_q[WIDTH-1]),
        .divisor     (divisor_q),
        .q_bit       (step_q_bit),
        .rem_next    (step_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        A_div_busy = 1'b0;
        A_div_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (A_div_start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                A_div_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                A_div_busy = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                A_div_busy = 1'b1;
                A_div_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            src1_q      <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (A_div_start) begin
                        dividend_q <= src1_mag;
                        divisor_q  <= src2_mag;
                        src1_q     <= A_div_src1;
                        q_neg_q    <= A_div_signed & (A_div_src1[WIDTH-1] ^ A_div_src2[WIDTH-1]);
                        r_neg_q    <= A_div_signed & A_div_src1[WIDTH-1];
                        dz_q       <= (A_div_src2 == '0);
                        rem_q      <= '0;
                        quot_q     <= '0;
                        cnt_q      <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    rem_q      <= step_rem;
                    quot_q     <= {quot_q[WIDTH-2:0], step_q_bit};
                    dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    // Divide-by-zero returns the raw dividend, never sign-fixed.
                    if (dz_q) begin
                        quotient_q  <= DZ_QUOT;
                        remainder_q <= src1_q;
                    end else begin
                        quotient_q  <= q_neg_q ? -quot_q : quot_q;
                        remainder_q <= r_neg_q ? -rem_q : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign A_div_quotient  = quotient_q;
    assign A_div_remainder = remainder_q;

endmodule

// File: tb/tb_nios1_nios2_qsys_div_cell.sv
// Directed-vector bench for the iterative divide cell: latency, busy window,
// signed/unsigned results, divide-by-zero, start-while-busy and reset.
module tb_nios1_nios2_qsys_div_cell;

    logic        clk;
    logic        reset;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sgn;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;

    int total;
    int bad;
    int cyc;
    int busy_n;
    int done_at;

    nios1_nios2_qsys_div_cell #(
        .WIDTH(32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .A_div_src1     (src1),
        .A_div_src2     (src2),
        .A_div_signed   (sgn),
        .A_div_start    (start),
        .A_div_busy     (busy),
        .A_div_done     (done),
        .A_div_quotient (quot),
        .A_div_remainder(rem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in an idle cycle; that cycle is cycle 0. Returns in cycle 1
    // with the operand inputs scrambled so late sampling would be visible.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        src1  = a;
        src2  = b;
        sgn   = s;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        src1    = ~a;
        src2    = b ^ 32'h5A5A_0001;
        sgn     = ~s;
        cyc     = 1;
        busy_n  = 0;
        done_at = -1;
    endtask

    task automatic run_until(input int limit);
        while (cyc < limit && !done) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        if (done) begin
            if (busy) busy_n++;
            done_at = cyc;
        end
    endtask

    task automatic finish_op(input string tag, input logic [31:0] eq, input logic [31:0] er);
        check({tag, "_done_cycle"}, 32'(done_at), 32'd34);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd34);
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
        @(negedge clk);
        cyc++;
        check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_quot_hold"}, quot, eq);
    endtask

    task automatic div_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] eq, input logic [31:0] er);
        launch(a, b, s);
        run_until(45);
        finish_op(tag, eq, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        src1  = 32'd100;
        src2  = 32'd7;
        sgn   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", quot, 32'd0);
        check("rst_rem", rem, 32'd0);
        @(negedge clk);
        check("rst_start_dropped", {31'd0, busy}, 32'd0);

        div_case("udiv_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        div_case("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        div_case("sdiv_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        div_case("sdiv_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2);
        div_case("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        div_case("udiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        div_case("sdiv_by_zero", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        div_case("udiv_by_zero", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        div_case("sdiv_neg_by_zero", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

        // Second start during cycle 10 must be ignored.
        launch(32'd100, 32'd7, 1'b0);
        run_until(10);
        src1  = 32'd50;
        src2  = 32'd3;
        sgn   = 1'b0;
        start = 1'b1;
        run_until(11);
        start = 1'b0;
        run_until(45);
        finish_op("busy_start_ignored", 32'd14, 32'd2);
        check("restart_cycle", 32'(cyc), 32'd35);
        div_case("restart_50_3", 32'd50, 32'd3, 1'b0, 32'd16, 32'd2);

        // Reset asserted during cycle 15 of an operation.
        launch(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        run_until(15);
        reset = 1'b1;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quot", quot, 32'd0);
        check("midrst_rem", rem, 32'd0);
        div_case("post_rst_div", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
